mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline.
- Sits beside the E-stage ALU and owns the HI/LO registers.
- Launches mult/multu/div/divu from the E stage and counts out the fixed latency of each operation.
- Drives the busy and stall signals the hazard logic uses to hold D-stage instructions that touch HI/LO.

---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide controller beside the E-stage ALU.
// Owns HI/LO, latches operands at launch, counts out a fixed latency and
// writes the result on the last busy edge. Raises stall_md for D-stage
// HI/LO users while an operation is launching or in flight.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        md_instr_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic on the latched operands only
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

  // Product and quotient/remainder of the latched operands; they have the
  // whole busy period to settle before being captured on the result edge.
  always_comb begin
    ext_a    = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b    = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod     = ext_a * ext_b;
    // Signed divide works on magnitudes so the most-negative / -1 case
    // falls out naturally as 0x80000000 with remainder 0.
    neg_a    = sgn_q & a_q[31];
    neg_b    = sgn_q & b_q[31];
    mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : (mag_a / mag_b);
    r_mag    = div_zero ? 32'd0 : (mag_a % mag_b);
    quo      = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem      = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state: launch from IDLE, count down, commit results on the last edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        // start is only honoured here, so a start while busy is dropped
        if (start) begin
          unique case (op)
            3'd0, 3'd1: begin
              a_d     = srcA;
              b_d     = srcB;
              sgn_d   = ~op[0];
              cnt_d   = MULT_LOAD;
              state_d = MUL;
            end
            3'd2, 3'd3: begin
              a_d     = srcA;
              b_d     = srcB;
              sgn_d   = ~op[0];
              cnt_d   = DIV_LOAD;
              state_d = DIV;
            end
            3'd4:    hi_d = srcA;
            3'd5:    lo_d = srcA;
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = 5'd0;
          state_d = IDLE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          // divide by zero burns the full latency but leaves HI/LO alone
          if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
          cnt_d   = 5'd0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign HI       = hi_q;
  assign LO       = lo_q;
  // Launch cycle is covered by the start term since busy is not yet high
  assign stall_md = md_instr_D & (busy | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and randomized checks of mdu_sequencer against
// an arithmetic reference model (64-bit integer multiply/divide).
module tb_mdu_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        md_instr_D;
  logic        busy, stall_md;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .md_instr_D(md_instr_D), .busy(busy), .HI(HI), .LO(LO), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  // Reference: MIPS semantics computed with plain 64-bit integer arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd2: if (b != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      3'd3: if (b != 0) begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      default: ;
    endcase
  endtask

  // Stimulus only: hold start for one cycle, then scramble the operand buses
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    md_instr_D = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", HI); end
    total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", LO); end
    total++; if (stall_md !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_md); end
    md_instr_D = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b want 0", busy); end
    $display("reset checked");
  endtask

  task automatic test_mult();
    logic [2:0]  ops[2];
    logic [31:0] as[2], bs[2], ehs[2], els[2];
    int n; logic early;
    ops[0] = 3'd0; as[0] = 32'hFFFFFFFE; bs[0] = 32'd3; ehs[0] = 32'hFFFFFFFF; els[0] = 32'hFFFFFFFA;
    ops[1] = 3'd1; as[1] = 32'hFFFFFFFF; bs[1] = 32'd2; ehs[1] = 32'h00000001; els[1] = 32'hFFFFFFFE;
    for (int i = 0; i < 2; i++) begin
      launch(ops[i], as[i], bs[i]);
      n = 0; early = 1'b0;
      while (busy === 1'b1 && n < 40) begin
        if (HI !== exp_hi || LO !== exp_lo) early = 1'b1;
        n++; step();
      end
      total++; if (n != MC) begin bad++; $display("FAIL mult%0d_latency: got %0d want %0d", i, n, MC); end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL mult%0d_early_write: got %b want 0", i, early); end
      total++; if (HI !== ehs[i]) begin bad++; $display("FAIL mult%0d_hi: got %h want %h", i, HI, ehs[i]); end
      total++; if (LO !== els[i]) begin bad++; $display("FAIL mult%0d_lo: got %h want %h", i, LO, els[i]); end
      exp_hi = ehs[i]; exp_lo = els[i];
      $display("mult op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", ops[i], as[i], bs[i], HI, LO, n);
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4];
    logic [31:0] as[4], bs[4], ehs[4], els[4];
    int n; logic early;
    ops[0] = 3'd2; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2; ehs[0] = 32'hFFFFFFFF; els[0] = 32'hFFFFFFFD;
    ops[1] = 3'd3; as[1] = 32'd7; bs[1] = 32'd0; ehs[1] = 32'hFFFFFFFF; els[1] = 32'hFFFFFFFD;
    ops[2] = 3'd2; as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF; ehs[2] = 32'd0; els[2] = 32'h80000000;
    ops[3] = 3'd3; as[3] = 32'hFFFFFFF9; bs[3] = 32'd2; ehs[3] = 32'd1; els[3] = 32'h7FFFFFFC;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i]);
      n = 0; early = 1'b0;
      while (busy === 1'b1 && n < 40) begin
        if (HI !== exp_hi || LO !== exp_lo) early = 1'b1;
        n++; step();
      end
      total++; if (n != DC) begin bad++; $display("FAIL div%0d_latency: got %0d want %0d", i, n, DC); end
      total++; if (early !== 1'b0) begin bad++; $display("FAIL div%0d_early_write: got %b want 0", i, early); end
      total++; if (HI !== ehs[i]) begin bad++; $display("FAIL div%0d_hi: got %h want %h", i, HI, ehs[i]); end
      total++; if (LO !== els[i]) begin bad++; $display("FAIL div%0d_lo: got %h want %h", i, LO, els[i]); end
      exp_hi = ehs[i]; exp_lo = els[i];
      $display("div op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", ops[i], as[i], bs[i], HI, LO, n);
    end
  endtask

  task automatic test_stall();
    int n; logic wrong;
    for (int m = 1; m >= 0; m--) begin
      md_instr_D = 1'(m);
      start = 1'b1; op = 3'd2; srcA = 32'd100; srcB = 32'd7;
      #1;
      total++; if (stall_md !== 1'(m)) begin bad++; $display("FAIL stall_launch_md%0d: got %b want %0d", m, stall_md, m); end
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; wrong = 1'b0;
      while (busy === 1'b1 && n < 40) begin
        if (stall_md !== 1'(m)) wrong = 1'b1;
        n++; step();
      end
      total++; if (wrong !== 1'b0 || n != DC) begin bad++; $display("FAIL stall_busy_md%0d: wrong=%b cycles=%0d want wrong=0 cycles=%0d", m, wrong, n, DC); end
      total++; if (stall_md !== 1'b0) begin bad++; $display("FAIL stall_after_md%0d: got %b want 0", m, stall_md); end
      exp_hi = 32'd2; exp_lo = 32'd14;
      total++; if (LO !== exp_lo || HI !== exp_hi) begin bad++; $display("FAIL stall_div_md%0d: got %h/%h want %h/%h", m, HI, LO, exp_hi, exp_lo); end
      $display("stall md_instr_D=%0d cycles=%0d stall_after=%b", m, n, stall_md);
    end
    md_instr_D = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    logic saw_busy;
    md_instr_D = 1'b1;
    start = 1'b1; op = 3'd4; srcA = 32'h12345678; srcB = $urandom;
    #1;
    total++; if (stall_md !== 1'b0) begin bad++; $display("FAIL mthi_stall: got %b want 0", stall_md); end
    @(posedge clk); #1;
    saw_busy = busy;
    op = 3'd5; srcA = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0; md_instr_D = 1'b0;
    saw_busy = saw_busy | busy;
    total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL mtx_busy: got %b want 0", saw_busy); end
    total++; if (HI !== 32'h12345678) begin bad++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
    total++; if (LO !== 32'h9ABCDEF0) begin bad++; $display("FAIL mtlo_lo: got %h want 9abcdef0", LO); end
    exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
    $display("mthi/mtlo -> hi=%h lo=%h", HI, LO);
  endtask

  task automatic test_busy_ignore();
    int n;
    launch(3'd0, 32'd7, 32'hFFFFFFFD);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 1) begin start = 1'b1; op = 3'd2; srcA = 32'd1000; srcB = 32'd10; end
      else if (n == 2) begin start = 1'b1; op = 3'd4; srcA = 32'hDEADBEEF; end
      else start = 1'b0;
      n++; step();
    end
    start = 1'b0;
    total++; if (n != MC) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", n, MC); end
    total++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin bad++; $display("FAIL ignore_result: got %h/%h want ffffffff/ffffffeb", HI, LO); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_relaunch: got %b want 0", busy); end
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFEB;
    $display("start while busy ignored -> hi=%h lo=%h cycles=%0d", HI, LO, n);
  endtask

  task automatic test_back_to_back();
    int n;
    launch(3'd1, 32'h00010000, 32'h00010000);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    total++; if (n != MC || HI !== 32'd1 || LO !== 32'd0) begin bad++; $display("FAIL b2b_first: got cycles=%0d %h/%h want %0d 00000001/00000000", n, HI, LO, MC); end
    // next op launches in the very cycle busy is first seen low
    launch(3'd3, 32'd1000, 32'd7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    total++; if (n != DC || HI !== 32'd6 || LO !== 32'd142) begin bad++; $display("FAIL b2b_second: got cycles=%0d %h/%h want %0d 00000006/0000008e", n, HI, LO, DC); end
    exp_hi = 32'd6; exp_lo = 32'd142;
    $display("back-to-back multu then divu -> hi=%h lo=%h", HI, LO);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, ph, pl;
    int n, lat, sel; logic early;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 9));
      else if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      ph = exp_hi; pl = exp_lo;
      model(o, a, b, exp_hi, exp_lo);
      lat = (o < 3'd2) ? MC : DC;
      launch(o, a, b);
      n = 0; early = 1'b0;
      while (busy === 1'b1 && n < 40) begin
        if (HI !== ph || LO !== pl) early = 1'b1;
        n++; step();
      end
      total++; if (n != lat || early !== 1'b0) begin bad++; $display("FAIL rand%0d_timing: got cycles=%0d early=%b want %0d early=0", i, n, early, lat); end
      total++; if (HI !== exp_hi || LO !== exp_lo) begin bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h/%h want %h/%h", i, o, a, b, HI, LO, exp_hi, exp_lo); end
      $display("rand op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", o, a, b, HI, LO, n);
    end
  endtask

  task automatic test_async_reset();
    logic leak;
    start = 1'b1; op = 3'd4; srcA = 32'hAAAA0000; step();
    op = 3'd5; srcA = 32'h00005555; step();
    start = 1'b0;
    launch(3'd0, 32'd3, 32'd5);
    step(); step();
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", busy); end
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL areset_hilo: got %h/%h want 0/0", HI, LO); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL areset_late_write: got %b want 0", leak); end
    exp_hi = 32'd0; exp_lo = 32'd0;
    $display("async reset mid-mult -> busy=%b hi=%h lo=%h", busy, HI, LO);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0; md_instr_D = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
